// File: rtl/ac_motor_deadtime_multi_pkg.sv
// Shared definitions for the multi-channel dead-time generator: channel FSM
// state encoding and the default counter width.
package ac_motor_pkg;

  localparam int DELAY_WIDTH_DEFAULT = 11;

  localparam logic [2:0] ST_OFF          = 3'd0;
  localparam logic [2:0] ST_DEAD_TO_HIGH = 3'd1;
  localparam logic [2:0] ST_HIGH_ON      = 3'd2;
  localparam logic [2:0] ST_DEAD_TO_LOW  = 3'd3;
  localparam logic [2:0] ST_LOW_ON       = 3'd4;

endpackage

// File: rtl/ac_motor_deadtime_multi_channel.sv
// One half-bridge: complementary gate drives with dead time, min ON pulse and
// abort of a dead interval when the command reverts to the side just left.
module ac_motor_deadtime_channel
  import ac_motor_pkg::*;
#(
  parameter int DELAY_WIDTH = DELAY_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   force_off,
  input  logic                   s,
  input  logic [DELAY_WIDTH-1:0] delay,
  input  logic [DELAY_WIDTH-1:0] min_pulse,
  output logic                   s_high,
  output logic                   s_low,
  output logic                   in_dead,
  output logic [2:0]             state
);

  logic [2:0]             state_d, state_q;
  logic [DELAY_WIDTH-1:0] dead_cnt_d, dead_cnt_q;
  logic [DELAY_WIDTH-1:0] on_cnt_d, on_cnt_q;
  logic [DELAY_WIDTH-1:0] on_cnt_inc;
  logic                   from_on_d, from_on_q;
  logic                   s_high_d, s_high_q;
  logic                   s_low_d, s_low_q;
  logic                   in_dead_d, in_dead_q;

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    on_cnt_d   = on_cnt_q;
    from_on_d  = from_on_q;
    on_cnt_inc = (on_cnt_q == '1) ? on_cnt_q : on_cnt_q + 1'b1;
    if (force_off) begin
      state_d    = ST_OFF;
      dead_cnt_d = '0;
      on_cnt_d   = '0;
      from_on_d  = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d    = s ? ST_DEAD_TO_HIGH : ST_DEAD_TO_LOW;
          dead_cnt_d = delay;
          from_on_d  = 1'b0;
        end
        // A revert only returns to the previous ON side if there was one;
        // coming from OFF the only safe move is to restart the other interval.
        ST_DEAD_TO_HIGH: begin
          if (!s) begin
            if (from_on_q) begin
              state_d = ST_LOW_ON;
            end else begin
              state_d    = ST_DEAD_TO_LOW;
              dead_cnt_d = delay;
            end
          end else if (dead_cnt_q == '0) begin
            state_d  = ST_HIGH_ON;
            on_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q - 1'b1;
          end
        end
        ST_DEAD_TO_LOW: begin
          if (s) begin
            if (from_on_q) begin
              state_d = ST_HIGH_ON;
            end else begin
              state_d    = ST_DEAD_TO_HIGH;
              dead_cnt_d = delay;
            end
          end else if (dead_cnt_q == '0) begin
            state_d  = ST_LOW_ON;
            on_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q - 1'b1;
          end
        end
        ST_HIGH_ON: begin
          on_cnt_d = on_cnt_inc;
          if (!s && on_cnt_q >= min_pulse) begin
            state_d    = ST_DEAD_TO_LOW;
            dead_cnt_d = delay;
            from_on_d  = 1'b1;
          end
        end
        ST_LOW_ON: begin
          on_cnt_d = on_cnt_inc;
          if (s && on_cnt_q >= min_pulse) begin
            state_d    = ST_DEAD_TO_HIGH;
            dead_cnt_d = delay;
            from_on_d  = 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
    s_high_d  = (state_d == ST_HIGH_ON);
    s_low_d   = (state_d == ST_LOW_ON);
    in_dead_d = (state_d == ST_DEAD_TO_HIGH) || (state_d == ST_DEAD_TO_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      dead_cnt_q <= '0;
      on_cnt_q   <= '0;
      from_on_q  <= 1'b0;
      s_high_q   <= 1'b0;
      s_low_q    <= 1'b0;
      in_dead_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      on_cnt_q   <= on_cnt_d;
      from_on_q  <= from_on_d;
      s_high_q   <= s_high_d;
      s_low_q    <= s_low_d;
      in_dead_q  <= in_dead_d;
    end
  end

  assign s_high  = s_high_q;
  assign s_low   = s_low_q;
  assign in_dead = in_dead_q;
  assign state   = state_q;

endmodule

// File: rtl/ac_motor_deadtime_multi.sv
// N-channel dead-time generator: input register, sticky fault latch and the
// enable/fault shutdown broadcast to one FSM per half-bridge.
module ac_motor_deadtime_multi
  import ac_motor_pkg::*;
#(
  parameter int CHANNELS         = 3,
  parameter int DELAY_WIDTH      = DELAY_WIDTH_DEFAULT,
  parameter bit DEFAULT_SIDE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DELAY_WIDTH-1:0] delay,
  input  logic [DELAY_WIDTH-1:0] min_pulse,
  input  logic                   fault,
  input  logic                   fault_clear,
  input  logic [CHANNELS-1:0]    s_in,
  output logic [CHANNELS-1:0]    s_high,
  output logic [CHANNELS-1:0]    s_low,
  output logic                   fault_latched,
  output logic [CHANNELS-1:0]    in_dead
);

  // With 1-bit commands the side is never ambiguous, so this is not consumed.
  localparam bit default_side_low_unused = DEFAULT_SIDE_LOW;

  logic [CHANNELS-1:0] s_d, s_q;
  logic                ready_d, ready_q;
  logic                fault_latched_d, fault_latched_q;
  logic                force_off;
  logic [2:0]          ch_state_unused [CHANNELS];

  // s_q holds no real command until the first edge after reset, so channels
  // stay OFF until then. The fault forces OFF on the same edge it latches.
  always_comb begin
    s_d             = s_in;
    ready_d         = 1'b1;
    fault_latched_d = fault | (fault_latched_q & ~fault_clear);
    force_off       = ~enable | fault_latched_d | ~ready_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q             <= '0;
      ready_q         <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      s_q             <= s_d;
      ready_q         <= ready_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ac_motor_deadtime_channel #(
      .DELAY_WIDTH (DELAY_WIDTH)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .force_off (force_off),
      .s         (s_q[g]),
      .delay     (delay),
      .min_pulse (min_pulse),
      .s_high    (s_high[g]),
      .s_low     (s_low[g]),
      .in_dead   (in_dead[g]),
      .state     (ch_state_unused[g])
    );
  end

  assign fault_latched = fault_latched_q;

endmodule
